tt_um_leg_solver: RTL and testbench
===================================

TT_UM_LEG_SOLVER -- requirements
Module: tt_um_leg_solver

Interface
REQ-001 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: ena  input  1  tile enable, ignored.
REQ-004 SHALL have port: ui_in  input  8  operand data bus.
REQ-005 SHALL have port: uio_in  input  8  bit0 ld_r (latch ui_in as r), bit1 start (latch ui_in as x and begin), bits7:2 ignored.
REQ-006 SHALL have port: uo_out  output  8  registered result y.
REQ-007 SHALL have port: uio_out  output  8  bit7 busy, bit6 done, bit5 err, bits4:0 constant 0.
REQ-008 SHALL have port: uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-009 SHALL compute y = floor(sqrt(r*r - x*x)) for unsigned 8-bit r and x, which recovers the missing leg from a hypotenuse r and a known leg x.
REQ-010 SHALL use no multiply operator, with squares formed by an iterative shift-add and the root formed by an iterative bitwise restoring method.
REQ-011 SHALL use FSM states IDLE, SQ, SUB, ROOT, DONE.
REQ-012 SHALL, when ld_r is high at a rising edge in IDLE, store ui_in as r; ld_r SHALL be ignored in all other states.
REQ-013 SHALL, when start is high at a rising edge E0 in IDLE, store ui_in as x, enter SQ and set busy=1; if ld_r and start are both high at E0, r SHALL take ui_in and x SHALL take ui_in.
REQ-014 SHALL, in SQ during edges E1..E8, process one multiplier bit per edge and form r*r and x*x in parallel in 16-bit accumulators.
REQ-015 SHALL, in SUB at edge E9, form the 17-bit difference r*r - x*x; a negative difference SHALL set an internal error flag and force the radicand to 0.
REQ-016 SHALL, in ROOT during edges E10..E17, resolve one result bit per edge, MSB first, with 16-bit compare width.
REQ-017 SHALL, at E18 in DONE, load uo_out with the result, drive done=1 and busy=0, and drive err equal to the error flag; done SHALL be high for exactly one cycle, after which the FSM returns to IDLE.
REQ-018 SHALL use a fixed latency, so the first cycle with done=1 follows E18 whether or not err is set.
REQ-019 SHALL hold uo_out and err stable from one DONE until the next DONE, and SHALL keep err from clearing at start.
REQ-020 SHALL ignore start while busy and SHALL never queue it.
REQ-021 SHALL retain r across operations, so repeated starts reuse the last r.

Reset
REQ-022 SHALL, on rst_n low, immediately force state IDLE, r=0, x=0, all accumulators 0, uo_out=0, busy=0, done=0, err=0.
REQ-023 SHALL, when reset is asserted mid-operation, abandon the operation with no done pulse; the first start after reset release SHALL behave per REQ-013.

Configuration
REQ-024 SHALL, when macro LEG_SOLVER_ROUND_EN is defined, round the result to nearest: after ROOT, when radicand > q*q + q, the result SHALL be q+1, saturated at 255, with latency unchanged.
REQ-025 SHALL, when LEG_SOLVER_ROUND_EN is undefined, output the floor result per REQ-009, with no rounding logic present.

Verification
REQ-026 SHALL pass scenario: ld_r with 5, then start with 3 -> done at E18, uo_out=4, err=0, busy high E0..E18.
REQ-027 SHALL pass scenario: r=255, x=0 -> uo_out=255, err=0 in both configurations.
REQ-028 SHALL pass scenario: r=10, x=20 -> uo_out=0, err=1, done at E18.
REQ-029 SHALL pass scenario: r=10, x=3 (radicand 91) -> uo_out=9 without LEG_SOLVER_ROUND_EN, 10 with it.
REQ-030 SHALL pass scenario: r=13, x=5, second start at E4, ld_r=1 with data 99 at E6 -> both ignored, uo_out=12 at E18, r still 13.
REQ-031 SHALL pass scenario: start at E0, rst_n low at E9, released, then r=13, x=12 -> no done pulse for the aborted run, outputs 0 during reset, next result uo_out=5.

Source files
------------

// File: rtl/tt_um_leg_solver.sv
// Missing-leg solver: y = floor(sqrt(r*r - x*x)) via shift-add squares and a restoring root.
// Optional LEG_SOLVER_ROUND_EN rounds the root to nearest (saturating at 255).
module tt_um_leg_solver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    IDLE, SQ, SUB, ROOT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  x_q, x_d;
  logic [15:0] ra_q, ra_d;
  logic [15:0] xa_q, xa_d;
  logic [15:0] rad_q, rad_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  root_q, root_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  y_q, y_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        erf_q, erf_d;

  logic        ld_r, start;
  logic [15:0] r_sh, x_sh;
  logic [16:0] diff;
  logic [15:0] rem_s, trial;
  logic [7:0]  res;
  logic        unused_ok;

  assign ld_r  = uio_in[0];
  assign start = uio_in[1];

  // partial products: operand shifted to the current multiplier bit weight
  assign r_sh = {8'b0, r_q} << cnt_q;
  assign x_sh = {8'b0, x_q} << cnt_q;

  assign diff = {1'b0, ra_q} - {1'b0, xa_q};

  // restoring root step: bring down two radicand bits, try (4*root + 1)
  assign rem_s = {rem_q[13:0], rad_q[15:14]};
  assign trial = {6'b0, root_q, 2'b01};

`ifdef LEG_SOLVER_ROUND_EN
  // remainder = rad - q*q, so rad > q*q + q is simply rem > q
  assign res = ((rem_q > {8'b0, root_q}) && (root_q != 8'hff))
             ? root_q + 8'd1 : root_q;
`else
  assign res = root_q;
`endif

  assign uo_out    = y_q;
  assign uio_out   = {busy_q, done_q, err_q, 5'b0};
  assign uio_oe    = 8'b1110_0000;
  assign unused_ok = ^{ena, uio_in[7:2]};

  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    x_d     = x_q;
    ra_d    = ra_q;
    xa_d    = xa_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    erf_d   = erf_q;
    unique case (state_q)
      IDLE: begin
        if (ld_r) r_d = ui_in;
        if (start) begin
          x_d     = ui_in;
          ra_d    = '0;
          xa_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SQ;
        end
      end
      SQ: begin
        if (r_q[cnt_q]) ra_d = ra_q + r_sh;
        if (x_q[cnt_q]) xa_d = xa_q + x_sh;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = SUB;
      end
      SUB: begin
        erf_d   = diff[16];
        rad_d   = diff[16] ? 16'd0 : diff[15:0];
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = ROOT;
      end
      ROOT: begin
        if (rem_s >= trial) begin
          rem_d  = rem_s - trial;
          root_d = {root_q[6:0], 1'b1};
        end else begin
          rem_d  = rem_s;
          root_d = {root_q[6:0], 1'b0};
        end
        rad_d = {rad_q[13:0], 2'b00};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        y_d     = res;
        err_d   = erf_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      x_q     <= '0;
      ra_q    <= '0;
      xa_q    <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      erf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      x_q     <= x_d;
      ra_q    <= ra_d;
      xa_q    <= xa_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      erf_q   <= erf_d;
    end
  end

endmodule

// File: tb/tb_tt_um_leg_solver.sv
// Bench for tt_um_leg_solver: scoreboard of expected {y, err} per start.
// Define LEG_SOLVER_ROUND_EN here too when building the rounding variant.
module tb_tt_um_leg_solver;

  typedef struct packed {
    logic [7:0] y;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int         pass_cnt = 0;
  int         tot = 0;
  exp_t       sb[$];
  logic [7:0] cur_r = '0;
  logic [7:0] last_y = '0;
  logic       last_err = 1'b0;

  tt_um_leg_solver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] r, input logic [7:0] x);
    exp_t o;
    int   rad;
    int   q;
    rad = int'(r) * int'(r) - int'(x) * int'(x);
    if (rad < 0) begin
      o.y = 8'd0;
      o.e = 1'b1;
      return o;
    end
    q = 0;
    while ((q + 1) * (q + 1) <= rad) q++;
`ifdef LEG_SOLVER_ROUND_EN
    if (rad - q * q > q && q < 255) q++;
`endif
    o.y = q[7:0];
    o.e = 1'b0;
    return o;
  endfunction

  task automatic do_ld(input logic [7:0] r);
    @(negedge clk);
    ui_in  = r;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    cur_r  = r;
  endtask

  // mode 1 injects a start at E4 and an ld_r of 99 at E6
  task automatic run_op(input logic [7:0] x, input int mode, input string nm);
    exp_t ex;
    int   got;
    logic held;
    @(negedge clk);
    ui_in  = x;
    uio_in = 8'h02;
    sb.push_back(model(cur_r, x));
    @(negedge clk);
    uio_in = 8'h00;
    tot++;
    if (uio_out[7] !== 1'b1)
      $display("FAIL %s busy_e0: got %b want 1", nm, uio_out[7]);
    else pass_cnt++;
    held = (uo_out === last_y) && (uio_out[5] === last_err);
    got  = 0;
    for (int k = 1; k <= 30; k++) begin
      if (mode == 1) begin
        if (k == 4) begin ui_in = 8'd77; uio_in = 8'h02; end
        if (k == 5) uio_in = 8'h00;
        if (k == 6) begin ui_in = 8'd99; uio_in = 8'h01; end
        if (k == 7) uio_in = 8'h00;
      end
      @(negedge clk);
      if (uio_out[6] === 1'b1) begin
        got = k;
        break;
      end
      if (uio_out[7] !== 1'b1) held = 1'b0;
      if (uo_out !== last_y || uio_out[5] !== last_err) held = 1'b0;
    end
    tot++;
    if (got != 18)
      $display("FAIL %s latency: got %0d want 18", nm, got);
    else pass_cnt++;
    tot++;
    if (held !== 1'b1)
      $display("FAIL %s hold_busy: got %b want 1", nm, held);
    else pass_cnt++;
    if (sb.size() == 0) begin
      tot++;
      $display("FAIL %s scoreboard: got empty want entry", nm);
      return;
    end
    ex = sb.pop_front();
    if (got != 0) begin
      tot++;
      if (uo_out !== ex.y)
        $display("FAIL %s y: got %0d want %0d", nm, uo_out, ex.y);
      else pass_cnt++;
      tot++;
      if (uio_out[5] !== ex.e)
        $display("FAIL %s err: got %b want %b", nm, uio_out[5], ex.e);
      else pass_cnt++;
      tot++;
      if (uio_out[7] !== 1'b0)
        $display("FAIL %s busy_done: got %b want 0", nm, uio_out[7]);
      else pass_cnt++;
      @(negedge clk);
      tot++;
      if (uio_out[6] !== 1'b0)
        $display("FAIL %s done_width: got %b want 0", nm, uio_out[6]);
      else pass_cnt++;
    end
    last_y   = ex.y;
    last_err = ex.e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tot++;
    if (uo_out !== 8'd0)
      $display("FAIL reset_y: got %0d want 0", uo_out);
    else pass_cnt++;
    tot++;
    if (uio_out !== 8'd0)
      $display("FAIL reset_uio: got %h want 00", uio_out);
    else pass_cnt++;
    tot++;
    if (uio_oe !== 8'he0)
      $display("FAIL uio_oe: got %h want e0", uio_oe);
    else pass_cnt++;
    rst_n = 1'b1;
    cur_r = '0;
    run_op(8'd0, 0, "zero_r");
  endtask

  task automatic test_basic();
    do_ld(8'd5);
    run_op(8'd3, 0, "r5_x3");
    do_ld(8'd255);
    run_op(8'd0, 0, "r255_x0");
  endtask

  task automatic test_err();
    do_ld(8'd10);
    run_op(8'd20, 0, "r10_x20");
    run_op(8'd3, 0, "r10_x3");
  endtask

  task automatic test_ignore();
    do_ld(8'd13);
    run_op(8'd5, 1, "r13_x5_inj");
    run_op(8'd5, 0, "r13_kept");
  endtask

  task automatic test_ld_and_start();
    @(negedge clk);
    ui_in  = 8'd40;
    uio_in = 8'h03;
    cur_r  = 8'd40;
    sb.push_back(model(8'd40, 8'd40));
    @(negedge clk);
    uio_in = 8'h00;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (uio_out[6] === 1'b1) break;
    end
    begin
      exp_t ex;
      ex = sb.pop_front();
      tot++;
      if (uo_out !== ex.y || uio_out[5] !== ex.e)
        $display("FAIL ld_start: got %0d/%b want %0d/%b",
                 uo_out, uio_out[5], ex.y, ex.e);
      else pass_cnt++;
      last_y   = ex.y;
      last_err = ex.e;
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_ld(8'd200);
    @(negedge clk);
    ui_in  = 8'd1;
    uio_in = 8'h02;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tot++;
    if (uo_out !== 8'd0 || uio_out !== 8'd0)
      $display("FAIL mid_reset_out: got %h/%h want 00/00", uo_out, uio_out);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    cur_r    = '0;
    last_y   = '0;
    last_err = 1'b0;
    seen     = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (uio_out[6] === 1'b1) seen = 1'b1;
    end
    tot++;
    if (seen !== 1'b0)
      $display("FAIL mid_reset_nodone: got %b want 0", seen);
    else pass_cnt++;
    do_ld(8'd13);
    run_op(8'd12, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      do_ld(8'($urandom_range(0, 255)));
      run_op(8'($urandom_range(0, 255)), 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_ignore();
    test_ld_and_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

endmodule
